// File: rtl/inverter_chain_freq_meter_if.sv
// Control/result bundle for the inverter-chain frequency meter.
// The master drives the measurement request; the slave (meter) returns status and result.
interface inverter_chain_freq_meter_if #(
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned GATE_W = 8,
  parameter int unsigned CNT_W  = 16
);
  logic              ena;
  logic              start;
  logic [SEL_W-1:0]  ch_sel;
  logic              invert;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output ena, start, ch_sel, invert, gate_len,
    input  busy, done, count, overflow
  );

  modport slave (
    input  ena, start, ch_sel, invert, gate_len,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/inverter_chain_freq_meter.sv
// Ring-oscillator frequency meter: synchronises a selected tap and counts its
// edges over a programmable window of clk cycles, holding the result for readout.
module inverter_chain_freq_meter #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned GATE_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0]             ch_in_i,
  inverter_chain_freq_meter_if.slave  meter_io
);

  localparam int unsigned SyncCntW = $clog2(SYNC_STAGES) + 1;
  localparam int unsigned TmrW     = (GATE_W > SyncCntW) ? GATE_W : SyncCntW;

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e              state_q, state_d;
  logic [TmrW-1:0]     tmr_q, tmr_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                inv_q, inv_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [CNT_W-1:0]    work_q, work_d;
  logic                ovf_q, ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;
  logic                prev_q;
  logic [N_CH-1:0]     sync_q [SYNC_STAGES];

  logic                sig;
  logic                edge_det;
  logic [CNT_W-1:0]    work_inc;
  logic                ovf_inc;

  // Every channel is synchronised continuously, so switching channels only needs
  // the ARM delay to refill prev_q from the new tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= ch_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sig;
    end
  end

  assign sig      = sync_q[SYNC_STAGES-1][sel_q];
  assign edge_det = inv_q ? (~sig & prev_q) : (sig & ~prev_q);

  always_comb begin
    work_inc = work_q;
    ovf_inc  = ovf_q;
    if (edge_det) begin
      if (work_q == '1) ovf_inc = 1'b1;
      else              work_inc = work_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    sel_d      = sel_q;
    inv_d      = inv_q;
    gate_d     = gate_q;
    work_d     = work_q;
    ovf_d      = ovf_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // The done cycle is still the tail of the previous measurement.
        if (meter_io.start && meter_io.ena && !done_q) begin
          state_d = StArm;
          tmr_d   = TmrW'(SYNC_STAGES - 1);
          sel_d   = (32'(meter_io.ch_sel) < N_CH) ? meter_io.ch_sel : '0;
          inv_d   = meter_io.invert;
          gate_d  = meter_io.gate_len;
          work_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      StArm: begin
        if (tmr_q == '0) begin
          if (gate_q == '0) begin
            state_d    = StIdle;
            done_d     = 1'b1;
            count_d    = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = StMeasure;
            tmr_d   = TmrW'(gate_q - 1'b1);
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StMeasure: begin
        work_d = work_inc;
        ovf_d  = ovf_inc;
        if (tmr_q == '0) begin
          state_d    = StIdle;
          done_d     = 1'b1;
          count_d    = work_inc;
          overflow_d = ovf_inc;
          work_d     = '0;
          ovf_d      = 1'b0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort keeps the previously published result untouched.
    if (state_q != StIdle && !meter_io.ena) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      count_d    = count_q;
      overflow_d = overflow_q;
      work_d     = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      tmr_q      <= '0;
      sel_q      <= '0;
      inv_q      <= 1'b0;
      gate_q     <= '0;
      work_q     <= '0;
      ovf_q      <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      sel_q      <= sel_d;
      inv_q      <= inv_d;
      gate_q     <= gate_d;
      work_q     <= work_d;
      ovf_q      <= ovf_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign meter_io.busy     = (state_q != StIdle);
  assign meter_io.done     = done_q;
  assign meter_io.count    = count_q;
  assign meter_io.overflow = overflow_q;

endmodule

// File: tb/tb_inverter_chain_freq_meter.sv
// Directed bench for the frequency meter; a 6-bit counter exposes saturation.
module tb_inverter_chain_freq_meter;

  localparam int unsigned NCh   = 4;
  localparam int unsigned CntW  = 6;
  localparam int unsigned GateW = 8;

  logic            clk;
  logic            rst_n;
  logic [NCh-1:0]  ch_in;
  int unsigned     half_p [NCh];
  int unsigned     ph_cnt [NCh];
  logic [NCh-1:0]  stat_v;

  int n_checks;
  int n_pass;

  inverter_chain_freq_meter_if #(.SEL_W(2), .GATE_W(GateW), .CNT_W(CntW)) bus ();

  inverter_chain_freq_meter #(
    .N_CH(NCh), .SEL_W(2), .CNT_W(CntW), .GATE_W(GateW), .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_in_i  (ch_in),
    .meter_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator taps: half_p == 0 holds the tap at stat_v.
  always @(negedge clk) begin
    for (int i = 0; i < NCh; i++) begin
      if (half_p[i] == 0) begin
        ch_in[i] = stat_v[i];
        ph_cnt[i] = 0;
      end else if (ph_cnt[i] >= half_p[i] - 1) begin
        ph_cnt[i] = 0;
        ch_in[i] = ~ch_in[i];
      end else begin
        ph_cnt[i] = ph_cnt[i] + 1;
      end
    end
  end

  task automatic do_start(input logic [1:0] sel, input logic inv, input logic [7:0] gate);
    @(negedge clk);
    bus.ch_sel   = sel;
    bus.invert   = inv;
    bus.gate_len = gate;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // Returns cycles since the accepting edge (1 = first cycle after it), or -1 on timeout.
  task automatic wait_done(input int limit, output int t);
    t = 1;
    while (!bus.done && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) t = -1;
  endtask

  task automatic test_reset();
    if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd0) $display("FAIL reset_count got %0d want 0", bus.count);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.overflow);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_basic();
    int t;
    do_start(2'd1, 1'b0, 8'd100);
    if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.busy);
    else n_pass++;
    n_checks++;
    wait_done(150, t);
    if (t !== 103) $display("FAIL basic_latency got %0d want 103", t);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd25) $display("FAIL basic_count got %0d want 25", bus.count);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL basic_ovf got %b want 0", bus.overflow);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL basic_busy_at_done got %b want 0", bus.busy);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    if (bus.done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", bus.done);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_saturate();
    int t;
    do_start(2'd0, 1'b0, 8'd200);
    wait_done(250, t);
    if (t !== 203) $display("FAIL sat_latency got %0d want 203", t);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd63) $display("FAIL sat_count got %0d want 63", bus.count);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL sat_ovf got %b want 1", bus.overflow);
    else n_pass++;
    n_checks++;
    half_p[0] = 4;
    repeat (10) @(negedge clk);
    do_start(2'd0, 1'b0, 8'd80);
    wait_done(120, t);
    if (bus.count !== 6'd10) $display("FAIL sat_next_count got %0d want 10", bus.count);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL sat_next_ovf got %b want 0", bus.overflow);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_gate_zero();
    int t;
    do_start(2'd1, 1'b0, 8'd0);
    if (bus.busy !== 1'b1) $display("FAIL gz_busy1 got %b want 1", bus.busy);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    if (bus.busy !== 1'b1) $display("FAIL gz_busy2 got %b want 1", bus.busy);
    else n_pass++;
    n_checks++;
    t = 2;
    while (!bus.done && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.done) t = -1;
    if (t !== 3) $display("FAIL gz_latency got %0d want 3", t);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd0) $display("FAIL gz_count got %0d want 0", bus.count);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_start_at_done();
    int t;
    do_start(2'd1, 1'b0, 8'd5);
    wait_done(30, t);
    bus.start  = 1'b1;
    bus.ch_sel = 2'd1;
    @(negedge clk);
    bus.start = 1'b0;
    if (bus.busy !== 1'b0) $display("FAIL done_cycle_start got busy %b want 0", bus.busy);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_restart_ignored();
    int ndone;
    int tfirst;
    ndone  = 0;
    tfirst = -1;
    do_start(2'd1, 1'b0, 8'd100);
    for (int t = 2; t <= 250; t++) begin
      @(negedge clk);
      if (t == 21) begin
        bus.start    = 1'b1;
        bus.ch_sel   = 2'd2;
        bus.gate_len = 8'd10;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        if (tfirst < 0) tfirst = t;
      end
    end
    if (ndone !== 1) $display("FAIL restart_ndone got %0d want 1", ndone);
    else n_pass++;
    n_checks++;
    if (tfirst !== 103) $display("FAIL restart_latency got %0d want 103", tfirst);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd25) $display("FAIL restart_count got %0d want 25", bus.count);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_ena_abort();
    int ndone;
    ndone = 0;
    do_start(2'd2, 1'b0, 8'd100);
    repeat (9) @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy);
    else n_pass++;
    n_checks++;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    if (ndone !== 0) $display("FAIL abort_ndone got %0d want 0", ndone);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd25) $display("FAIL abort_count got %0d want 25", bus.count);
    else n_pass++;
    n_checks++;
    bus.ena = 1'b1;
  endtask

  task automatic test_reset_mid();
    int t;
    do_start(2'd1, 1'b0, 8'd100);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd0) $display("FAIL rstmid_count got %0d want 0", bus.count);
    else n_pass++;
    n_checks++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_start(2'd1, 1'b0, 8'd8);
    wait_done(30, t);
    if (bus.count !== 6'd2) $display("FAIL rstmid_toggle_count got %0d want 2", bus.count);
    else n_pass++;
    n_checks++;
    do_start(2'd3, 1'b0, 8'd20);
    wait_done(40, t);
    if (t !== 23) $display("FAIL static_latency got %0d want 23", t);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd0) $display("FAIL static_count got %0d want 0", bus.count);
    else n_pass++;
    n_checks++;
  endtask

  task automatic test_invert();
    int t;
    do_start(2'd2, 1'b1, 8'd60);
    wait_done(90, t);
    if (t !== 63) $display("FAIL inv_latency got %0d want 63", t);
    else n_pass++;
    n_checks++;
    if (bus.count !== 6'd10) $display("FAIL inv_count got %0d want 10", bus.count);
    else n_pass++;
    n_checks++;
  endtask

  initial begin
    n_checks     = 0;
    n_pass       = 0;
    half_p[0]    = 1;
    half_p[1]    = 2;
    half_p[2]    = 3;
    half_p[3]    = 0;
    stat_v       = 4'b1000;
    ch_in        = '0;
    for (int i = 0; i < NCh; i++) ph_cnt[i] = 0;
    rst_n        = 1'b0;
    bus.ena      = 1'b1;
    bus.start    = 1'b0;
    bus.ch_sel   = 2'd0;
    bus.invert   = 1'b0;
    bus.gate_len = 8'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    test_basic();
    test_saturate();
    test_gate_zero();
    test_start_at_done();
    repeat (2) @(negedge clk);
    test_restart_ignored();
    test_ena_abort();
    test_reset_mid();
    test_invert();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
